simd_addsub_pipe: RTL
=====================

SIMD_ADDSUB_PIPE -- requirements
Module: simd_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total datapath width in bits.
REQ-002 SHALL have parameter LANE_W, default 4, packed-lane width in bits; WIDTH SHALL be an integer multiple of LANE_W; LANES = WIDTH/LANE_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand set on a/b/mode/sat is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A, two's complement.
REQ-008 b  input  WIDTH  operand B, two's complement.
REQ-009 mode  input  2  00 ADD, 01 SUB (A-B), 10 PADD (per-lane add), 11 PSUB (per-lane A-B).
REQ-010 sat  input  1  saturate full-width result in ADD/SUB; ignored in PADD/PSUB.
REQ-011 flush  input  1  discard all in-flight transactions.
REQ-012 out_valid  output  1  result/flags valid.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 result  output  WIDTH  sum/difference.
REQ-015 cout  output  1  full-width carry-out (SUB: 1 = no borrow); 0 in PADD/PSUB.
REQ-016 flag_n, flag_z, flag_v  output  1 each  negative, zero, overflow.
REQ-017 lane_ovf  output  LANES  per-lane overflow; all zero in ADD/SUB.

Function
REQ-018 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-019 SHALL be a two-stage pipeline (S1, S2); result appears on out_valid exactly 2 cycles after acceptance when unstalled; throughput one transaction per cycle.
REQ-020 in_ready SHALL equal !S1.valid || S1 advances; S1 advances when !S2.valid || out_ready; in_ready never depends combinationally on in_valid.
REQ-021 While out_valid && !out_ready, result, cout, flags and lane_ovf SHALL hold stable; no transaction is dropped, duplicated or reordered.
REQ-022 SUB/PSUB SHALL compute A + ~B + 1 (per lane in PSUB, each lane carry-in 1); no carry crosses lane boundaries in PADD/PSUB.
REQ-023 Overflow (per lane or full width): sign(A) == sign(effective B) && sign(raw result) != sign(A), effective B = B in add modes, ~B in subtract modes.
REQ-024 Saturation on overflow: sign(A)=0 -> max positive (0111..1); sign(A)=1 -> min negative (1000..0); applies per lane in PADD/PSUB always, full width in ADD/SUB only when sat=1.
REQ-025 flag_v = full-width overflow in ADD/SUB, OR of lane_ovf in PADD/PSUB; reported pre-saturation.
REQ-026 flag_n = result[WIDTH-1] and flag_z = (result == 0), both on the final (post-saturation) result.
REQ-027 cout SHALL be the raw full-width carry, unaffected by saturation.
REQ-028 flush=1 SHALL clear S1.valid and S2.valid at the next edge and force in_ready=0 that cycle; flush overrides a simultaneous acceptance.
REQ-029 Simultaneous output transfer and input acceptance at full occupancy SHALL advance every stage without bubble.

Reset
REQ-030 rst_n=0 at a rising edge SHALL clear S1.valid and S2.valid regardless of in-flight state or flush.
REQ-031 After reset, out_valid=0, result=0, cout=0, flag_n=0, flag_z=0, flag_v=0, lane_ovf=0; in_ready=1 the first cycle rst_n=1.
REQ-032 During rst_n=0, in_ready SHALL be 0 and no operand is accepted.

Verification (WIDTH=16, LANE_W=4)
REQ-033 ADD sat=0, a=0x7FFF, b=0x0001 -> 2 cycles later result=0x8000, flag_v=1, flag_n=1, cout=0.
REQ-034 ADD sat=1, a=0x7FFF, b=0x0001 -> result=0x7FFF, flag_v=1, flag_n=0; SUB sat=1, a=0x8000, b=0x0001 -> result=0x8000, flag_v=1.
REQ-035 SUB a=0x0005, b=0x0005 -> result=0x0000, flag_z=1, cout=1, flag_v=0.
REQ-036 PADD a=0x7812, b=0x1811 -> result=0x7823, lane_ovf=4'b1100, flag_v=1, cout=0.
REQ-037 Stream 3 ADDs with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, first result held stable, all 3 delivered in order once out_ready=1.
REQ-038 rst_n=0 (or flush=1) with both stages valid -> next edge out_valid=0, no stale result emitted afterward.

Source files
------------

// File: rtl/simd_addsub_pipe.sv
// Two-stage SIMD adder/subtractor: S1 registers the operands, S2 registers the
// computed result and flags. Full-width ADD/SUB with optional saturation, or per-lane saturating PADD/PSUB.
module simd_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4,
    localparam int LANES = WIDTH / LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [1:0]        mode,
    input  logic              sat,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              cout,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic [LANES-1:0]  lane_ovf
);

    localparam logic [WIDTH-1:0]  FULL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  FULL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    // Stage 1: captured operands
    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic              s1_sat_q, s1_sat_d;

    // Stage 2: final result and flags
    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s2_result_q, s2_result_d;
    logic              s2_cout_q, s2_cout_d;
    logic              s2_n_q, s2_n_d;
    logic              s2_z_q, s2_z_d;
    logic              s2_v_q, s2_v_d;
    logic [LANES-1:0]  s2_lane_ovf_q, s2_lane_ovf_d;

    logic              s1_adv;
    logic              accept;

    // Datapath between S1 and S2
    logic              is_sub;
    logic              is_packed;
    logic [WIDTH-1:0]  eff_b;
    logic [WIDTH:0]    full_sum;
    logic              full_ovf;
    logic [LANE_W:0]   lane_sum;
    logic [WIDTH-1:0]  lane_res;
    logic [LANES-1:0]  lane_ov;
    logic [WIDTH-1:0]  calc_result;
    logic              calc_cout;
    logic              calc_v;
    logic [LANES-1:0]  calc_lane_ovf;

    // in_ready deliberately ignores in_valid so upstream never sees a combinational loop.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = rst_n && !flush && (!s1_valid_q || s1_adv);
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_sub    = s1_mode_q[0];
        is_packed = s1_mode_q[1];
        eff_b     = is_sub ? ~s1_b_q : s1_b_q;
        full_sum  = {1'b0, s1_a_q} + {1'b0, eff_b} + {{WIDTH{1'b0}}, is_sub};
        full_ovf  = (s1_a_q[WIDTH-1] == eff_b[WIDTH-1]) && (full_sum[WIDTH-1] != s1_a_q[WIDTH-1]);

        lane_sum = '0;
        lane_res = '0;
        lane_ov  = '0;
        // Each lane gets its own carry-in so nothing propagates across lane boundaries.
        for (int i = 0; i < LANES; i++) begin
            lane_sum = {1'b0, s1_a_q[i*LANE_W +: LANE_W]} + {1'b0, eff_b[i*LANE_W +: LANE_W]}
                     + {{LANE_W{1'b0}}, is_sub};
            lane_ov[i] = (s1_a_q[i*LANE_W+LANE_W-1] == eff_b[i*LANE_W+LANE_W-1])
                      && (lane_sum[LANE_W-1] != s1_a_q[i*LANE_W+LANE_W-1]);
            if (lane_ov[i]) begin
                lane_res[i*LANE_W +: LANE_W] = s1_a_q[i*LANE_W+LANE_W-1] ? LANE_MIN : LANE_MAX;
            end else begin
                lane_res[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
            end
        end

        if (is_packed) begin
            calc_result   = lane_res;
            calc_cout     = 1'b0;
            calc_v        = |lane_ov;
            calc_lane_ovf = lane_ov;
        end else begin
            if (s1_sat_q && full_ovf) begin
                calc_result = s1_a_q[WIDTH-1] ? FULL_MIN : FULL_MAX;
            end else begin
                calc_result = full_sum[WIDTH-1:0];
            end
            calc_cout     = full_sum[WIDTH];
            calc_v        = full_ovf;
            calc_lane_ovf = '0;
        end
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_mode_d     = s1_mode_q;
        s1_sat_d      = s1_sat_q;
        s2_valid_d    = s2_valid_q;
        s2_result_d   = s2_result_q;
        s2_cout_d     = s2_cout_q;
        s2_n_d        = s2_n_q;
        s2_z_d        = s2_z_q;
        s2_v_d        = s2_v_q;
        s2_lane_ovf_d = s2_lane_ovf_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_mode_d  = mode;
            s1_sat_d   = sat;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d   = calc_result;
                s2_cout_d     = calc_cout;
                s2_n_d        = calc_result[WIDTH-1];
                s2_z_d        = (calc_result == '0);
                s2_v_d        = calc_v;
                s2_lane_ovf_d = calc_lane_ovf;
            end
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_mode_q     <= '0;
            s1_sat_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_result_q   <= '0;
            s2_cout_q     <= 1'b0;
            s2_n_q        <= 1'b0;
            s2_z_q        <= 1'b0;
            s2_v_q        <= 1'b0;
            s2_lane_ovf_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_mode_q     <= s1_mode_d;
            s1_sat_q      <= s1_sat_d;
            s2_valid_q    <= s2_valid_d;
            s2_result_q   <= s2_result_d;
            s2_cout_q     <= s2_cout_d;
            s2_n_q        <= s2_n_d;
            s2_z_q        <= s2_z_d;
            s2_v_q        <= s2_v_d;
            s2_lane_ovf_q <= s2_lane_ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign cout      = s2_cout_q;
    assign flag_n    = s2_n_q;
    assign flag_z    = s2_z_q;
    assign flag_v    = s2_v_q;
    assign lane_ovf  = s2_lane_ovf_q;

endmodule
